// File: rtl/cg_rvarch_pkg.sv
// Shared RV architectural constants and writeback request types.
package cg_rvarch_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/cg_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector, starting the search at a
// registered pointer that moves to one past the winner after each grant.
module cg_rr_arbiter #(
    parameter  int NUM_REQ = 3,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               srst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W:0]   cand_sum;
    logic [IDX_W-1:0] cand;

    // Walk the requesters in priority order ptr, ptr+1, ... modulo NUM_REQ.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand_sum    = '0;
        cand        = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand_sum = {1'b0, ptr_reg} + (IDX_W+1)'(off);
            if (cand_sum >= (IDX_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = cand_sum[IDX_W-1:0];
            if (!grant_valid && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_valid = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_valid) begin
            ptr_next = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/cg_rvarch_wb_arbiter.sv
// Writeback arbiter owning the regfile write port: x0 filter, stall gating, round-robin
// grant and registered rd stage. Optional forwarding under CG_RVARCH_WB_ARB_FWD_EN.
module cg_rvarch_wb_arbiter
    import cg_rvarch_pkg::*;
#(
    parameter  int NUM_REQ    = 3,
    parameter  int DATA_WIDTH = XLEN,
    parameter  int ADDR_WIDTH = REG_ADDR_W,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic                          i_stall,
    output logic                          o_rd_we,
    output logic [ADDR_WIDTH-1:0]         o_rd_addr,
    output logic [DATA_WIDTH-1:0]         o_rd_data,
    output logic [ID_W-1:0]               o_grant_id
`ifdef CG_RVARCH_WB_ARB_FWD_EN
    ,
    input  logic [ADDR_WIDTH-1:0]         i_rs1_addr,
    input  logic [ADDR_WIDTH-1:0]         i_rs2_addr,
    output logic                          o_rs1_fwd_valid,
    output logic [DATA_WIDTH-1:0]         o_rs1_fwd_data,
    output logic                          o_rs2_fwd_valid,
    output logic [DATA_WIDTH-1:0]         o_rs2_fwd_data
`endif
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
    logic [DATA_WIDTH-1:0] req_data [NUM_REQ];
    logic [NUM_REQ-1:0]    x0_ack;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  grant_valid;

    logic                  rd_we_reg;
    logic [ADDR_WIDTH-1:0] rd_addr_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic [ID_W-1:0]       grant_id_reg;

    // x0 writes are acknowledged and dropped; they never compete for the write port.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_addr[gi] = i_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign req_data[gi] = i_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign x0_ack[gi]   = i_req_valid[gi] && (req_addr[gi] == ZERO_ADDR) && !i_rst;
            assign eligible[gi] = i_req_valid[gi] && (req_addr[gi] != ZERO_ADDR)
                                  && !i_stall && !i_rst;
        end
    endgenerate

    cg_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk         (i_clk),
        .srst        (i_rst),
        .req         (eligible),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign o_req_ready = grant | x0_ack;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_we_reg    <= 1'b0;
            rd_addr_reg  <= '0;
            rd_data_reg  <= '0;
            grant_id_reg <= '0;
        end else begin
            rd_we_reg <= grant_valid;
            if (grant_valid) begin
                rd_addr_reg  <= req_addr[grant_idx];
                rd_data_reg  <= req_data[grant_idx];
                grant_id_reg <= grant_idx;
            end
        end
    end

    assign o_rd_we    = rd_we_reg;
    assign o_rd_addr  = rd_addr_reg;
    assign o_rd_data  = rd_data_reg;
    assign o_grant_id = grant_id_reg;

`ifdef CG_RVARCH_WB_ARB_FWD_EN
    // Bypass the write sitting in the output stage, which the regfile has not committed yet.
    assign o_rs1_fwd_valid = rd_we_reg && (rd_addr_reg == i_rs1_addr) && (i_rs1_addr != ZERO_ADDR);
    assign o_rs2_fwd_valid = rd_we_reg && (rd_addr_reg == i_rs2_addr) && (i_rs2_addr != ZERO_ADDR);
    assign o_rs1_fwd_data  = o_rs1_fwd_valid ? rd_data_reg : '0;
    assign o_rs2_fwd_data  = o_rs2_fwd_valid ? rd_data_reg : '0;
`endif

endmodule
